vertex_transform_pipe: RTL and testbench



---
 rtl/vertex_transform_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_vertex_transform_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform_pipe.sv
// -----------------------------------------------------------------------------
// vertex_transform_pipe
//
// Purpose:
//    Multi-cycle vertex transform for the geometry stage. One object-space
//    vertex and a 4x4 projection matrix are accepted over a valid/ready
//    handshake. The unit then runs three steps:
//       1. A matrix multiply into clip space, one row per cycle.
//       2. A perspective divide into NDC. This uses 1/w from an iterative
//          restoring divider.
//       3. A viewport mapping.
//    The screen-space vertex is returned over a second valid/ready handshake.
//    All scalars are signed fixed point: WIDTH bits total, FRAC of them
//    fractional. Multiplies are (a*b)>>>FRAC and are truncated (they wrap).
//
// Ports:
//    i_clk, i_reset_n   clock, asynchronous active-low reset
//    i_valid / o_ready  input handshake (o_ready high only when idle)
//    i_vertex           {w,z,y,x}, x in the LSBs
//    i_matrix           row-major 4x4, element (r,c) at index 4r+c, index 0 LSBs
//    i_screen_width     fixed-point screen width
//    i_screen_height    fixed-point screen height
//    o_valid / i_ready  output handshake
//    o_vertex           {inv_w, z_ndc, y_screen, x_screen}
//    o_w_zero           clip-space w was exactly zero
//    o_clipped          (only with VERTEX_CLIP_FLAG_EN) vertex lies outside
//                       the clip volume, or clip w <= 0
//
// Optional feature macro: VERTEX_CLIP_FLAG_EN
// -----------------------------------------------------------------------------
module vertex_transform_pipe #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [4*WIDTH-1:0]    i_vertex,
   input  logic [16*WIDTH-1:0]   i_matrix,
   input  logic [WIDTH-1:0]      i_screen_width,
   input  logic [WIDTH-1:0]      i_screen_height,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [4*WIDTH-1:0]    o_vertex,
   output logic                  o_w_zero
`ifdef VERTEX_CLIP_FLAG_EN
   ,
   output logic                  o_clipped
`endif
);

   localparam int RSTEPS = 2*FRAC + 1;            // one quotient bit per cycle
   localparam int CW     = $clog2(RSTEPS + 1);

   typedef logic signed [WIDTH-1:0] scalar_t;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_RECIP = 3'd2,
      S_NDC   = 3'd3,
      S_VIEW  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   function automatic scalar_t fmul(input scalar_t a, input scalar_t b);
      logic signed [2*WIDTH-1:0] p;
      p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      return scalar_t'(p >>> FRAC);
   endfunction

`ifdef VERTEX_CLIP_FLAG_EN
   function automatic logic [WIDTH-1:0] absu(input scalar_t a);
      return a[WIDTH-1] ? -a : a;
   endfunction
`endif

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   scalar_t           vtx_q [4], vtx_d [4];
   scalar_t           mat_q [16], mat_d [16];
   scalar_t           sw_q, sw_d, sh_q, sh_d;
   scalar_t           clip_q [4], clip_d [4];
   scalar_t           ndc_q [3], ndc_d [3];
   scalar_t           inv_w_q, inv_w_d;
   logic [WIDTH-1:0]  rem_q, rem_d, quo_q, quo_d;
   logic              w_zero_q, w_zero_d;
   logic [4*WIDTH-1:0] out_vertex_q, out_vertex_d;
   logic              out_w_zero_q, out_w_zero_d;
`ifdef VERTEX_CLIP_FLAG_EN
   logic              clipped_q, clipped_d;
`endif

   // Combinational helpers
   logic [1:0]                mul_row;
   logic signed [2*WIDTH-1:0] mul_sum;
   scalar_t                   mul_res;
   logic [WIDTH-1:0]          w_abs;
   logic [WIDTH:0]            rem_sh;
   logic                      rem_ge;
   scalar_t                   inv_w_c;
   scalar_t                   half_w, half_h;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      vtx_d        = vtx_q;
      mat_d        = mat_q;
      sw_d         = sw_q;
      sh_d         = sh_q;
      clip_d       = clip_q;
      ndc_d        = ndc_q;
      inv_w_d      = inv_w_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      w_zero_d     = w_zero_q;
      out_vertex_d = out_vertex_q;
      out_w_zero_d = out_w_zero_q;
`ifdef VERTEX_CLIP_FLAG_EN
      clipped_d    = clipped_q;
`endif

      // Row cnt of M times v. The four products are summed at full width and
      // shifted once, so intermediate fractional bits are not lost.
      mul_row = cnt_q[1:0];
      mul_sum = '0;
      for (int c = 0; c < 4; c++) begin
         mul_sum = mul_sum + (2*WIDTH)'(mat_q[{mul_row, 2'(c)}]) * (2*WIDTH)'(vtx_q[c]);
      end
      mul_res = scalar_t'(mul_sum >>> FRAC);

      // Restoring division of 2^(2*FRAC) by |w|. The dividend has a single
      // set bit, its MSB. That bit is shifted in on the first step only.
      w_abs   = clip_q[3][WIDTH-1] ? -clip_q[3] : clip_q[3];
      rem_sh  = {rem_q, (cnt_q == '0)};
      rem_ge  = rem_sh >= {1'b0, w_abs};
      inv_w_c = clip_q[3][WIDTH-1] ? scalar_t'(-quo_q) : scalar_t'(quo_q);

      half_w  = sw_q >>> 1;
      half_h  = sh_q >>> 1;

      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               for (int i = 0; i < 4; i++)  vtx_d[i] = i_vertex[i*WIDTH +: WIDTH];
               for (int i = 0; i < 16; i++) mat_d[i] = i_matrix[i*WIDTH +: WIDTH];
               sw_d     = i_screen_width;
               sh_d     = i_screen_height;
               cnt_d    = '0;
               w_zero_d = 1'b0;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            clip_d[mul_row] = mul_res;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(3)) begin
               cnt_d = '0;
               rem_d = '0;
               quo_d = '0;
               // A zero w has no reciprocal. Skip the divider and leave the
               // quotient at zero, so inv_w is 0 and x/y land on the screen centre.
               if (mul_res == '0) begin
                  w_zero_d = 1'b1;
                  state_d  = S_NDC;
               end else begin
                  state_d  = S_RECIP;
               end
            end
         end
         S_RECIP: begin
            rem_d = rem_ge ? WIDTH'(rem_sh - {1'b0, w_abs}) : rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(RSTEPS - 1)) state_d = S_NDC;
         end
         S_NDC: begin
            inv_w_d = inv_w_c;
            for (int i = 0; i < 3; i++) ndc_d[i] = fmul(clip_q[i], inv_w_c);
            state_d = S_VIEW;
         end
         S_VIEW: begin
            out_vertex_d = {inv_w_q, ndc_q[2],
                            fmul(ndc_q[1], half_h) + half_h,
                            fmul(ndc_q[0], half_w) + half_w};
            out_w_zero_d = w_zero_q;
`ifdef VERTEX_CLIP_FLAG_EN
            clipped_d    = (absu(clip_q[0]) > w_abs) || (absu(clip_q[1]) > w_abs) ||
                           (absu(clip_q[2]) > w_abs) || clip_q[3][WIDTH-1] ||
                           (clip_q[3] == '0);
`endif
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         for (int i = 0; i < 4; i++)  vtx_q[i]  <= '0;
         for (int i = 0; i < 16; i++) mat_q[i]  <= '0;
         for (int i = 0; i < 4; i++)  clip_q[i] <= '0;
         for (int i = 0; i < 3; i++)  ndc_q[i]  <= '0;
         sw_q         <= '0;
         sh_q         <= '0;
         inv_w_q      <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         w_zero_q     <= 1'b0;
         out_vertex_q <= '0;
         out_w_zero_q <= 1'b0;
`ifdef VERTEX_CLIP_FLAG_EN
         clipped_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vtx_q        <= vtx_d;
         mat_q        <= mat_d;
         clip_q       <= clip_d;
         ndc_q        <= ndc_d;
         sw_q         <= sw_d;
         sh_q         <= sh_d;
         inv_w_q      <= inv_w_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         w_zero_q     <= w_zero_d;
         out_vertex_q <= out_vertex_d;
         out_w_zero_q <= out_w_zero_d;
`ifdef VERTEX_CLIP_FLAG_EN
         clipped_q    <= clipped_d;
`endif
      end
   end

   assign o_ready  = (state_q == S_IDLE);
   assign o_valid  = (state_q == S_DONE);
   assign o_vertex = out_vertex_q;
   assign o_w_zero = out_w_zero_q;
`ifdef VERTEX_CLIP_FLAG_EN
   assign o_clipped = clipped_q;
`endif

endmodule

// File: tb/tb_vertex_transform_pipe.sv
// -----------------------------------------------------------------------------
// tb_vertex_transform_pipe
//
// Scoreboard bench for vertex_transform_pipe at its default parameters (16.16).
// Stimulus issues vertices and pushes the expected result when a vertex is
// accepted. A monitor compares every cycle in which o_valid is high, and pops
// the entry on the output handshake. Directed cases carry hand-derived
// results. Random cases use a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_vertex_transform_pipe;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [127:0] i_vertex = '0;
   logic [511:0] i_matrix = '0;
   logic [31:0]  sw = '0, sh = '0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic [127:0] o_vertex;
   logic         o_w_zero;
`ifdef VERTEX_CLIP_FLAG_EN
   logic         o_clipped;
`endif

   vertex_transform_pipe dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_vertex        (i_vertex),
      .i_matrix        (i_matrix),
      .i_screen_width  (sw),
      .i_screen_height (sh),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_vertex        (o_vertex),
      .o_w_zero        (o_w_zero)
`ifdef VERTEX_CLIP_FLAG_EN
      ,
      .o_clipped       (o_clipped)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] v;
      logic         wz;
      logic         clp;
      int           acc;
      int           lat;
      int           id;
   } ent_t;

   ent_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   n_id = 0;
   bit   hold_low = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int fm(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return int'(p >>> 16);
   endfunction

   function automatic longint labs(input int a);
      return (a < 0) ? -longint'(a) : longint'(a);
   endfunction

   // Reference model: clip = M*v, inv_w = 2^32 / |w| (wrapped to 32 bits, signed
   // like w), ndc = clip*inv_w, screen = ndc*half + half.
   function automatic ent_t model(input logic [127:0] v, input logic [511:0] m,
                                  input logic [31:0] swv, input logic [31:0] shv);
      ent_t e;
      int vv[4];
      int clip[4];
      int ndc[3];
      int inv, hw, hh, x, y;
      longint s;
      longint unsigned a, q;
      for (int i = 0; i < 4; i++) vv[i] = int'(v[32*i +: 32]);
      for (int r = 0; r < 4; r++) begin
         s = 0;
         for (int c = 0; c < 4; c++)
            s = s + longint'(int'(m[32*(4*r+c) +: 32])) * longint'(vv[c]);
         clip[r] = int'(s >>> 16);
      end
      if (clip[3] == 0) begin
         inv = 0; e.wz = 1'b1; e.lat = 6;
      end else begin
         a = labs(clip[3]);
         q = (64'd1 << 32) / a;
         inv = int'(q);
         if (clip[3] < 0) inv = -inv;
         e.wz = 1'b0; e.lat = 39;
      end
      for (int i = 0; i < 3; i++) ndc[i] = fm(clip[i], inv);
      hw = int'(swv) >>> 1;
      hh = int'(shv) >>> 1;
      x = fm(ndc[0], hw) + hw;
      y = fm(ndc[1], hh) + hh;
      e.v = {inv, ndc[2], y, x};
      e.clp = (labs(clip[0]) > labs(clip[3])) || (labs(clip[1]) > labs(clip[3])) ||
              (labs(clip[2]) > labs(clip[3])) || (clip[3] <= 0);
      e.acc = 0;
      e.id = 0;
      return e;
   endfunction

   task automatic send(input logic [127:0] v, input logic [511:0] m,
                       input logic [31:0] swv, input logic [31:0] shv,
                       input ent_t e, input bit keep);
      int waited;
      waited = 0;
      @(posedge clk); #1;
      i_vertex = v; i_matrix = m; sw = swv; sh = shv; i_valid = 1'b1;
      @(negedge clk);
      while (!o_ready) begin
         waited++;
         if (waited > 400) begin
            total++; bad++;
            $display("FAIL accept_timeout: o_ready=%b expected 1", o_ready);
            i_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      e.acc = cyc + 1;
      e.id  = n_id++;
      if (keep) sb.push_back(e);
      @(posedge clk); #1;
      // Scramble inputs after acceptance: the unit must have captured them.
      i_valid  = 1'b0;
      i_vertex = {4{$urandom}};
      i_matrix = {16{$urandom}};
      sw = $urandom;
      sh = $urandom;
   endtask

   task automatic send_exp(input logic [127:0] v, input logic [511:0] m,
                           input logic [31:0] swv, input logic [31:0] shv,
                           input logic [127:0] exp_v, input logic wz, input int lat);
      ent_t e;
      e = model(v, m, swv, shv);
      e.v = exp_v; e.wz = wz; e.lat = lat;
      send(v, m, swv, shv, e, 1'b1);
   endtask

   function automatic logic [31:0] small_fx();
      return 32'((int'($urandom_range(0, 32)) - 16) <<< 14);
   endfunction

   // Downstream ready: random, or forced low for the backpressure case.
   initial begin
      forever begin
         @(posedge clk); #1;
         i_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor
   initial begin
      bit   prev_v, after;
      ent_t e;
      int   lat;
      prev_v = 1'b0; after = 1'b0; lat = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0; after = 1'b0;
            continue;
         end
         if (after) begin
            chk("ready_after_handoff", o_ready, 1);
            chk("valid_after_handoff", o_valid, 0);
         end
         after = 1'b0;
         if (o_valid) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: o_vertex=%h with no pending vertex", o_vertex);
            end else begin
               e = sb[0];
               if (!prev_v) begin
                  lat = cyc - e.acc;
                  chk("latency", lat, e.lat);
               end
               chk("vertex", o_vertex, e.v);
               chk("w_zero", o_w_zero, e.wz);
               chk("ready_in_done", o_ready, 0);
`ifdef VERTEX_CLIP_FLAG_EN
               chk("clipped", o_clipped, e.clp);
`endif
               if (i_ready) begin
                  void'(sb.pop_front());
                  $display("txn %0d: vertex=%h w_zero=%b latency=%0d", e.id, o_vertex, o_w_zero, lat);
                  after = 1'b1;
               end
            end
         end
         prev_v = o_valid;
      end
   end

   // Stimulus
   initial begin
      logic [511:0] m_id, m_proj, m_zero, m_b;
      logic [127:0] v1, v2, v3, v;
      logic [511:0] m;
      logic [31:0]  s640, s480, a, b;
      int           mode, waited;
      ent_t         e;

      s640 = 32'h0280_0000;
      s480 = 32'h01E0_0000;
      m_id = '0;
      for (int r = 0; r < 4; r++) m_id[32*(5*r) +: 32] = 32'h0001_0000;
      m_proj = m_id;
      m_proj[32*15 +: 32] = 32'h0;
      m_proj[32*14 +: 32] = 32'h0001_0000;
      m_zero = '0;
      v1 = {32'h0001_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
      v2 = {32'h0001_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0002_0000};
      v3 = {32'h0001_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_0000};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_ready", o_ready, 1);
      chk("reset_valid", o_valid, 0);
      chk("reset_vertex", o_vertex, 0);
      chk("reset_w_zero", o_w_zero, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Identity with 10 cycles of backpressure in DONE
      hold_low = 1'b1;
      send_exp(v1, m_id, s640, s480,
               {32'h0001_0000, 32'h0003_0000, 32'h02D0_0000, 32'h0280_0000}, 1'b0, 39);
      waited = 0;
      while (!o_valid && waited < 100) begin @(posedge clk); waited++; end
      if (!o_valid) begin
         total++; bad++;
         $display("FAIL done_timeout: o_valid=%b expected 1", o_valid);
      end
      repeat (10) @(posedge clk);
      hold_low = 1'b0;

      // Projection row 3 = (0,0,1,0)
      send_exp(v2, m_proj, s640, s480,
               {32'h0000_4000, 32'h0001_0000, 32'h00B4_0000, 32'h01E0_0000}, 1'b0, 39);
      send_exp(v3, m_proj, s640, s480,
               {32'hFFFF_8000, 32'h0001_0000, 32'h0078_0000, 32'h00A0_0000}, 1'b0, 39);
      // Zero matrix: w == 0
      send_exp(v1, m_zero, s640, s480,
               {32'h0, 32'h0, 32'h00F0_0000, 32'h0140_0000}, 1'b1, 6);

      // |w| of one LSB (reciprocal wraps) and w = most negative value
      m_b = m_id; m_b[32*15 +: 32] = 32'h0000_0001;
      send(v1, m_b, s640, s480, model(v1, m_b, s640, s480), 1'b1);
      m_b[32*15 +: 32] = 32'h8000_0000;
      send(v1, m_b, s640, s480, model(v1, m_b, s640, s480), 1'b1);

      // Reset in the middle of RECIP: the in-flight vertex is dropped
      waited = 0;
      while (sb.size() != 0 && waited < 2000) begin @(posedge clk); waited++; end
      send(v2, m_proj, s640, s480, model(v2, m_proj, s640, s480), 1'b0);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_valid", o_valid, 0);
      chk("midreset_ready", o_ready, 1);
      chk("midreset_vertex", o_vertex, 0);
      chk("midreset_w_zero", o_w_zero, 0);
      send_exp(v1, m_id, s640, s480,
               {32'h0001_0000, 32'h0003_0000, 32'h02D0_0000, 32'h0280_0000}, 1'b0, 39);

      // Random vertices
      for (int t = 0; t < 40; t++) begin
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++)  v[32*i +: 32] = (mode == 1) ? $urandom : small_fx();
         for (int i = 0; i < 16; i++) m[32*i +: 32] = (mode == 1) ? $urandom : small_fx();
         if (mode == 2) m[32*12 +: 128] = '0;
         a = (mode == 1) ? $urandom : (32'($urandom_range(1, 2048)) << 16);
         b = (mode == 1) ? $urandom : (32'($urandom_range(1, 2048)) << 16);
         e = model(v, m, a, b);
         send(v, m, a, b, e, 1'b1);
      end

      waited = 0;
      while (sb.size() != 0 && waited < 3000) begin @(posedge clk); waited++; end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
